// File: rtl/pkt_loop_buf.sv
// pkt_loop_buf: circular packet loopback buffer.
// Rx packets commit to a length queue; a TX FSM replays them.
module pkt_loop_buf #(
    parameter int DW = 8,
    parameter int AW = 11,
    parameter int QD = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rxdat_vld,
    input  logic [DW-1:0]          rxdat,
    input  logic                   rxdat_end,
    input  logic                   dat_tx_end,
    output logic                   o_dat_tx_req,
    input  logic                   dat_tx_rden,
    output logic [DW-1:0]          o_dat,
    output logic [15:0]            o_dat_len,
    output logic                   o_ts,
    output logic [$clog2(QD):0]    o_pkt_cnt,
    output logic [15:0]            o_drop_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam int QW = $clog2(QD);
    localparam int CW = QW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    logic [DW-1:0] mem [DEPTH];
    logic [15:0]   q_len [QD];
    logic [QW-1:0] q_wr, q_rd;
    logic [AW-1:0] wr_ptr, wr_start, rd_ptr, pkt_base;
    logic [AW:0]   used;
    logic [15:0]   cur_len, rd_cnt, end_len;
    logic [31:0]   free_w;
    logic          ovf, ovf_now, acc, ignore, drop, commit, pop, rd_ok;
    state_t        state;

    assign free_w  = 32'(DEPTH) - 32'(used) - 32'(cur_len);
    assign ovf_now = rxdat_vld && (free_w == 32'd0 || cur_len == 16'hFFFF);
    assign acc     = rxdat_vld && !ovf && !ovf_now;
    assign end_len = cur_len + 16'(acc);
    // A bare end marker with nothing received is not a packet
    assign ignore  = cur_len == 16'd0 && !rxdat_vld && !ovf;
    assign drop    = rxdat_end && !ignore
                  && (ovf || ovf_now || o_pkt_cnt == CW'(QD));
    assign commit  = rxdat_end && !ignore && !drop;
    assign pop     = state == DONE;
    assign rd_ok   = state == SEND && dat_tx_rden && rd_cnt < o_dat_len;
    assign o_ts    = state == DONE;

    // Data RAM write port, no reset so it maps to block RAM
    always_ff @(posedge clk) begin
        if (acc) mem[wr_ptr] <= rxdat;
    end

    // Rx side: write pointer, packet length, overflow, commit/drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            wr_start   <= '0;
            cur_len    <= '0;
            ovf        <= 1'b0;
            q_wr       <= '0;
            o_drop_cnt <= '0;
            for (int i = 0; i < QD; i++) q_len[i] <= '0;
        end else begin
            if (acc) begin
                wr_ptr  <= wr_ptr + 1'b1;
                cur_len <= cur_len + 16'd1;
            end
            if (ovf_now) ovf <= 1'b1;
            if (commit) begin
                wr_start    <= wr_ptr + AW'(acc);
                cur_len     <= '0;
                q_len[q_wr] <= end_len;
                q_wr        <= q_wr + 1'b1;
            end
            if (drop) begin
                wr_ptr  <= wr_start;
                cur_len <= '0;
                ovf     <= 1'b0;
                if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

    // Occupancy: net effect of same-cycle commit and release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used      <= '0;
            o_pkt_cnt <= '0;
        end else begin
            used <= used
                  + (commit ? (AW+1)'(end_len) : '0)
                  - (pop ? (AW+1)'(o_dat_len) : '0);
            o_pkt_cnt <= o_pkt_cnt + CW'(commit) - CW'(pop);
        end
    end

    // TX FSM: load head packet, serve reads, release on done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            q_rd         <= '0;
            pkt_base     <= '0;
            rd_ptr       <= '0;
            rd_cnt       <= '0;
            o_dat_len    <= '0;
            o_dat_tx_req <= 1'b0;
            o_dat        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (o_pkt_cnt != '0) state <= LOAD;
                end
                LOAD: begin
                    o_dat_len    <= q_len[q_rd];
                    rd_ptr       <= pkt_base;
                    rd_cnt       <= '0;
                    o_dat_tx_req <= 1'b1;
                    state        <= SEND;
                end
                SEND: begin
                    if (rd_ok) begin
                        o_dat  <= mem[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                        rd_cnt <= rd_cnt + 16'd1;
                    end
                    if (dat_tx_end) state <= DONE;
                end
                DONE: begin
                    o_dat_tx_req <= 1'b0;
                    q_rd         <= q_rd + 1'b1;
                    pkt_base     <= pkt_base + AW'(o_dat_len);
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pkt_loop_buf.md
PKT_LOOP_BUF -- requirements
Module: pkt_loop_buf

Interface
REQ-001 SHALL have parameter DW, default 8: data byte width.
REQ-002 SHALL have parameter AW, default 11: data buffer address width; DEPTH = 2^AW words.
REQ-003 SHALL have parameter QD, default 4: length-queue depth in packets (power of 2, >=2).
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port rxdat_vld, input, 1: rx word strobe.
REQ-007 SHALL have port rxdat, input, DW: rx word.
REQ-008 SHALL have port rxdat_end, input, 1: end-of-packet pulse; may coincide with the last rxdat_vld.
REQ-009 SHALL have port dat_tx_end, input, 1: transmitter finished the current packet.
REQ-010 SHALL have port o_dat_tx_req, output, 1: packet ready, request transmit.
REQ-011 SHALL have port dat_tx_rden, input, 1: transmitter read strobe.
REQ-012 SHALL have port o_dat, output, DW: read data.
REQ-013 SHALL have port o_dat_len, output, 16: length of the packet offered.
REQ-014 SHALL have port o_ts, output, 1: one-cycle pulse in TX state DONE.
REQ-015 SHALL have port o_pkt_cnt, output, $clog2(QD)+1: committed packets queued.
REQ-016 SHALL have port o_drop_cnt, output, 16: dropped packets, saturating.

Function
REQ-017 SHALL store rx words in a circular DEPTH-word buffer (inferred RAM); wr/rd pointers AW bits, wrapping DEPTH-1 -> 0.
REQ-018 SHALL track wr_start (start of current rx packet), wr_ptr and cur_len (16 b); rxdat_vld writes at wr_ptr, increments both.
REQ-019 SHALL keep used = committed words not yet released; free = DEPTH - used - cur_len.
REQ-020 SHALL set sticky ovf and discard the word when rxdat_vld arrives with free == 0 or cur_len == 16'hFFFF; ovf clears at packet end.
REQ-021 SHALL, on rxdat_end (counting a coincident rxdat_vld word), commit the packet: push cur_len into the length queue, used += cur_len, wr_start <= new wr_ptr, cur_len <= 0.
REQ-022 SHALL drop instead of commit when ovf is set or the length queue is full: wr_ptr <= wr_start, cur_len <= 0, o_drop_cnt += 1 (saturates at 16'hFFFF).
REQ-023 SHALL ignore rxdat_end with cur_len == 0 and no coincident word (no push, no drop).
REQ-024 SHALL run the TX FSM IDLE -> LOAD -> SEND -> DONE -> IDLE; o_ts = (state == DONE).
REQ-025 IDLE: go to LOAD when length queue non-empty.
REQ-026 LOAD (1 cycle): o_dat_len <= queue head, rd_ptr <= pkt base, rd_cnt <= 0; o_dat_tx_req <= 1 on exit.
REQ-027 SEND: each dat_tx_rden with rd_cnt < o_dat_len reads RAM[rd_ptr], rd_ptr++, rd_cnt++; o_dat valid the cycle after rden; rden with rd_cnt == o_dat_len ignored, o_dat holds.
REQ-028 SEND: dat_tx_end -> DONE regardless of rd_cnt; dat_tx_end outside SEND ignored.
REQ-029 DONE: o_dat_tx_req <= 0, pop queue, pkt base += o_dat_len (releasing unread words), used -= o_dat_len.
REQ-030 SHALL apply same-cycle commit and release with net used update; same-cycle push and pop keep o_pkt_cnt unchanged.
REQ-031 o_pkt_cnt SHALL equal queued entries including the one in service until its pop.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear: state IDLE, all pointers, used, cur_len, ovf, queue, o_dat_tx_req, o_dat, o_dat_len, o_pkt_cnt, o_drop_cnt to 0; RAM contents undefined.
REQ-033 SHALL, on reset mid-packet or mid-transmit, discard all buffered data; first post-reset commit has pkt base 0.

Verification
REQ-034 5 words 0x11..0x15, end with last word -> req after 3 cycles, o_dat_len=5, five rdens return 0x11..0x15 one cycle late, tx_end -> o_ts pulse, req low, o_pkt_cnt 0.
REQ-035 Three packets (3,1,4 words) back-to-back, no tx -> o_pkt_cnt=3; served in order with lengths 3,1,4.
REQ-036 AW=3, 10-word packet -> dropped, o_drop_cnt=1, next 2-word packet sent correctly from pkt base 0.
REQ-037 QD+1 packets while transmitter stalled -> last dropped, o_pkt_cnt=QD.
REQ-038 tx_end after 2 of 6 words -> next packet starts at base+6, correct data.
REQ-039 rst_n low during SEND -> req low immediately, counters 0, new packet delivered normally.
